// File: rtl/tp_pad_driver.sv
// tp_pad_driver: drives one test-point pad from a run-time selected probe.
// Each probe bit is synchronized. Rising edges on the active channel are
// counted, and each edge is stretched into a fixed-width pad pulse.
//
// Optional feature macro: TP_PAD_DRIVER_STRETCH_EN
//   defined   -> IDLE/PULSE/GAP stretcher FSM drives TP_OUT
//   undefined -> TP_OUT is a registered copy of the synchronized probe,
//                and BUSY is tied to 0
//
// Ports:
//   CLK        system clock, rising edge
//   RESET_N    async active-low reset
//   PROBE      probe sources, asynchronous to CLK
//   SEL        requested channel, loaded on SEL_STB
//   SEL_STB    single-cycle select strobe
//   CNT_CLR    synchronous clear of EDGE_CNT
//   TP_OUT     registered pad drive
//   ACTIVE_SEL currently selected channel
//   EDGE_CNT   saturating rising-edge count on the active channel
//   BUSY       stretcher not idle
module tp_pad_driver #(
    parameter int unsigned NPROBE  = 8,
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned STRETCH = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NPROBE-1:0] PROBE,
    input  logic [SEL_W-1:0]  SEL,
    input  logic              SEL_STB,
    input  logic              CNT_CLR,
    output logic              TP_OUT,
    output logic [SEL_W-1:0]  ACTIVE_SEL,
    output logic [CNT_W-1:0]  EDGE_CNT,
    output logic              BUSY
);

    localparam int unsigned NSEL = 2 ** SEL_W;

    // Elaboration-time parameter sanity
    if (STRETCH < 1) begin : g_bad_stretch
        $error("tp_pad_driver: STRETCH must be at least 1");
    end
    if (NSEL < NPROBE) begin : g_bad_sel_w
        $error("tp_pad_driver: SEL_W too narrow for NPROBE");
    end

    // Two-flop synchronizer on every probe bit
    logic [NPROBE-1:0] s1;
    logic [NPROBE-1:0] s2;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= PROBE;
            s2 <= s1;
        end
    end

    // Pad s2 to the full select range so any SEL value indexes safely
    logic [NSEL-1:0] s2_pad;
    assign s2_pad = NSEL'(s2);

    logic sel_ok_c;
    logic load_c;
    logic prev;
    logic edge_c;

    assign sel_ok_c = (32'(SEL) < NPROBE);
    assign load_c   = SEL_STB & sel_ok_c;
    assign edge_c   = s2_pad[ACTIVE_SEL] & ~prev;

    // Channel select and edge-history flop; a load primes prev from the new
    // channel so switching never looks like an edge
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ACTIVE_SEL <= '0;
            prev       <= 1'b0;
        end else if (load_c) begin
            ACTIVE_SEL <= SEL;
            prev       <= s2_pad[SEL];
        end else begin
            prev       <= s2_pad[ACTIVE_SEL];
        end
    end

    // Saturating edge counter: load > clear > increment
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            EDGE_CNT <= '0;
        end else if (load_c || CNT_CLR) begin
            EDGE_CNT <= '0;
        end else if (edge_c && (EDGE_CNT != {CNT_W{1'b1}})) begin
            EDGE_CNT <= EDGE_CNT + CNT_W'(1);
        end
    end

`ifdef TP_PAD_DRIVER_STRETCH_EN

    localparam int unsigned DCNT_W = (STRETCH > 1) ? $clog2(STRETCH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DCNT_W-1:0] dcnt;
    logic [DCNT_W-1:0] dcnt_nx;
    logic              gap_last;
    logic              gap_last_nx;

    // Stretcher state, pulse counter and registered outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            dcnt     <= '0;
            gap_last <= 1'b0;
            TP_OUT   <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_nx;
            dcnt     <= dcnt_nx;
            gap_last <= gap_last_nx;
            TP_OUT   <= (state_nx == ST_PULSE);
            BUSY     <= (state_nx != ST_IDLE);
        end
    end

    // Next-state: PULSE holds STRETCH cycles, GAP holds two, select load aborts
    always_comb begin
        state_nx    = state;
        dcnt_nx     = dcnt;
        gap_last_nx = gap_last;
        unique case (state)
            ST_IDLE: begin
                if (edge_c) begin
                    state_nx = ST_PULSE;
                    dcnt_nx  = DCNT_W'(STRETCH - 1);
                end
            end
            ST_PULSE: begin
                if (dcnt == '0) begin
                    state_nx    = ST_GAP;
                    gap_last_nx = 1'b0;
                end else begin
                    dcnt_nx = dcnt - DCNT_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_last) begin
                    state_nx = ST_IDLE;
                end else begin
                    gap_last_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        if (load_c) begin
            state_nx = ST_IDLE;
        end
    end

`else

    // Level follower: registered copy of the synchronized active probe
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            TP_OUT <= 1'b0;
        end else if (load_c) begin
            TP_OUT <= 1'b0;
        end else begin
            TP_OUT <= s2_pad[ACTIVE_SEL];
        end
    end

    assign BUSY = 1'b0;

`endif

endmodule

// File: doc/tp_pad_driver.md
# tp_pad_driver

Drives a single board test-point pad from one of several internal probe signals, selected at run time. It synchronizes the selected probe to the system clock, detects rising edges, and stretches each one into a fixed-width pulse so that single-cycle trigger events are visible on a scope. It also counts edges on the selected channel. It sits between the trigger-utility logic, which supplies the probe sources, and the TP_PAD_LS test-point pad, which is the sink for TP_OUT.

## Interface
- NPROBE, 8, number of probe inputs
- SEL_W, 3, select width; must satisfy 2^SEL_W >= NPROBE
- STRETCH, 16, TP_OUT high time in CLK cycles; minimum 1
- CNT_W, 8, edge-counter width
- CLK  input  1  system clock, rising-edge active
- RESET_N  input  1  reset, asynchronous assert, active-low
- PROBE  input  NPROBE  probe sources, asynchronous to CLK
- SEL  input  SEL_W  requested channel
- SEL_STB  input  1  single-cycle strobe that loads SEL
- CNT_CLR  input  1  synchronous clear of EDGE_CNT
- TP_OUT  output  1  registered pad drive, connects to TP_PAD_LS.A
- ACTIVE_SEL  output  SEL_W  currently selected channel
- EDGE_CNT  output  CNT_W  saturating count of rising edges on the active channel
- BUSY  output  1  high while the stretcher is not in IDLE

## Operation
- **Synchronizer:** every PROBE bit passes through a 2-flop synchronizer (s1, s2). One `prev` flop holds the s2 value of the active channel. Edge detect: `edge = s2[ACTIVE_SEL] & ~prev`.
- **Select load:** on SEL_STB with SEL < NPROBE, the following happen on that clock edge:
  - ACTIVE_SEL <= SEL.
  - The FSM is forced to IDLE and TP_OUT to 0.
  - EDGE_CNT is cleared.
  - `prev` is loaded with s2[SEL], so there is no false edge from the channel switch.
- **Out-of-range select:** SEL_STB with SEL >= NPROBE is ignored entirely.
- **FSM states:** IDLE, PULSE, GAP.
  - IDLE: TP_OUT=0. On `edge`, go to PULSE and load the down-counter with STRETCH-1.
  - PULSE: TP_OUT=1. Decrement each cycle; when the counter reaches 0, go to GAP.
  - GAP: TP_OUT=0 for exactly 2 cycles, then go to IDLE.
  - Edges seen during PULSE or GAP do not retrigger the FSM, but they are still counted.
- **BUSY:** equals (state != IDLE), registered together with the state.
- **Edge counter:**
  - Increments by 1 on each `edge`.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - CNT_CLR has priority over an increment in the same cycle.
  - A select load has priority over both CNT_CLR and an increment.
- **Reset:** RESET_N low asynchronously clears all flops, all outputs, ACTIVE_SEL (to 0) and the counter, and puts the FSM in IDLE.
  - A reset in mid-pulse drops TP_OUT immediately.
  - `prev` resets to 0, so a probe held high through reset release produces exactly one edge, one pulse and one count.

## Timing
- PROBE must be stable high across CLK edge k.
  - s2 is high after edge k+1.
  - `edge` is asserted during cycle k+1→k+2.
  - TP_OUT rises after edge k+2, i.e. 3 registered stages from the first sampling edge.
- TP_OUT stays high for exactly STRETCH cycles, then low for at least 2 cycles.
- Minimum edge-to-edge spacing for every edge to produce its own pulse: STRETCH+2 cycles.
- EDGE_CNT updates on the same edge on which the FSM leaves IDLE (cycle k+2).
- A probe high pulse must last at least 2 CLK periods to be detected reliably. Shorter pulses may be missed; this is not an error.
- SEL_STB → ACTIVE_SEL and TP_OUT=0 take effect after 1 edge.
- Reset values: TP_OUT=0, ACTIVE_SEL=0, EDGE_CNT=0, BUSY=0.

## Configuration
- **TP_PAD_DRIVER_STRETCH_EN defined:** the stretcher FSM described above is built.
- **TP_PAD_DRIVER_STRETCH_EN undefined:**
  - The FSM and down-counter are omitted.
  - TP_OUT is a registered copy of s2[ACTIVE_SEL], following the probe level with the same 3-edge latency.
  - BUSY is tied to 0.
  - The synchronizer, select logic and edge counter are unchanged.

## Test plan
- **Single-edge pulse:** STRETCH_EN defined, STRETCH=16. Reset, then hold PROBE[0] high from edge 10 → TP_OUT high from edge 12 through edge 28, low for edges 28–30, EDGE_CNT=1, BUSY high for 18 cycles.
- **Retrigger suppression:** edges on PROBE[0] at cycles 10, 14 and 40 → two TP_OUT pulses (from 12 and from 42), EDGE_CNT=3.
- **Select change mid-pulse:** PROBE[2] held high. During PULSE on channel 0, issue SEL_STB with SEL=2 → TP_OUT=0 next cycle, ACTIVE_SEL=2, EDGE_CNT=0, no pulse on channel 2 until it falls and rises again. SEL=9 with NPROBE=8 → no change.
- **Counter saturation and clear:** 300 spaced edges → EDGE_CNT=255. CNT_CLR asserted in the same cycle as an edge → EDGE_CNT=0.
- **Reset mid-pulse:** RESET_N low during PULSE → TP_OUT, BUSY and EDGE_CNT are 0 without waiting for a CLK edge. Release with PROBE[0] high → exactly one pulse, EDGE_CNT=1.
- **Stretcher compiled out:** TP_PAD_DRIVER_STRETCH_EN undefined. PROBE[0] high for cycles 10–12 → TP_OUT high for edges 12–14 only, BUSY stays 0.
